// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer and the instruction decoder.
// Also holds the branch-condition evaluation used by the FLAGS state.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_SHL = 3'd4,
    OP_SHR = 3'd5,
    OP_CMP = 3'd6,
    OP_TST = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    COND_NEVER = 2'd0,
    COND_Z     = 2'd1,
    COND_N     = 2'd2,
    COND_NZ    = 2'd3
  } cond_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_B = 2'd1,
    EXEC   = 2'd2,
    FLAGS  = 2'd3
  } state_t;

  localparam logic [1:0] ALU_OP_ADDSUB = 2'b00;
  localparam logic [1:0] ALU_OP_AND    = 2'b01;
  localparam logic [1:0] ALU_OP_XOR    = 2'b10;
  localparam logic [1:0] ALU_OP_SHIFT  = 2'b11;

  function automatic logic cond_eval(cond_t cond, logic zero, logic negative);
    case (cond)
      COND_Z:  return zero;
      COND_N:  return negative;
      COND_NZ: return ~zero;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_decode.sv
// Op decode into ALU control fields; shared with the instruction decoder.
// CMP and TST reuse the SUB and AND datapaths but never write a result.
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  op_t        i_op,
  output logic [1:0] o_aluOp,
  output logic       o_subShiftDir,
  output logic       o_writesResult
);

  // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    o_aluOp        = ALU_OP_ADDSUB;
    o_subShiftDir  = 1'b0;
    o_writesResult = 1'b1;
    case (i_op)
      OP_ADD: ;
      OP_SUB: o_subShiftDir = 1'b1;
      OP_AND: o_aluOp = ALU_OP_AND;
      OP_XOR: o_aluOp = ALU_OP_XOR;
      OP_SHL: begin
        o_aluOp       = ALU_OP_SHIFT;
        o_subShiftDir = 1'b1;
      end
      OP_SHR: o_aluOp = ALU_OP_SHIFT;
      OP_CMP: begin
        o_subShiftDir  = 1'b1;
        o_writesResult = 1'b0;
      end
      OP_TST: begin
        o_aluOp        = ALU_OP_AND;
        o_writesResult = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU instruction: optional B load, execute, flag check, done.
// All outputs decode from the registered state and latched fields.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [1:0]       i_cond,
  input  logic             i_reuseB,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_b,
  output logic             o_bWr,
  output logic             o_oe,
  output logic [1:0]       o_aluOp,
  output logic             o_subShiftDir,
  input  logic             i_zero,
  input  logic             i_negative,
  output logic             o_resultWr,
  output logic             o_done,
  output logic             o_condTaken
);

  state_t           state_q, state_d;
  op_t              op_q;
  cond_t            cond_q;
  logic [WIDTH-1:0] b_q;
  logic             writes_result;
  logic             accept;

  assign accept = (state_q == IDLE) && i_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Latched fields are reset as well so o_b and the decode read 0 after reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      op_q   <= OP_ADD;
      cond_q <= COND_NEVER;
      b_q    <= '0;
    end else if (accept) begin
      op_q   <= op_t'(i_op);
      cond_q <= cond_t'(i_cond);
      b_q    <= i_b;
    end
  end

  alu_op_decode u_decode (
    .i_op           (op_q),
    .o_aluOp        (o_aluOp),
    .o_subShiftDir  (o_subShiftDir),
    .o_writesResult (writes_result)
  );

  assign o_b = b_q;

  always_comb begin
    state_d     = state_q;
    o_ready     = 1'b0;
    o_bWr       = 1'b0;
    o_oe        = 1'b0;
    o_resultWr  = 1'b0;
    o_done      = 1'b0;
    o_condTaken = 1'b0;
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_d = i_reuseB ? EXEC : LOAD_B;
      end
      LOAD_B: begin
        o_bWr   = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        o_oe       = 1'b1;
        o_resultWr = writes_result;
        state_d    = FLAGS;
      end
      FLAGS: begin
        o_done      = 1'b1;
        o_condTaken = cond_eval(cond_q, i_zero, i_negative);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench: sequencer driving a behavioural 8-bit ALU, A from the bench.
// Expected results come from op semantics, pushed at accept and popped at o_done.
module tb_alu_sequencer;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_valid;
  logic       o_ready;
  logic [2:0] i_op;
  logic [1:0] i_cond;
  logic       i_reuseB;
  logic [7:0] i_b;
  logic [7:0] o_b;
  logic       o_bWr;
  logic       o_oe;
  logic [1:0] o_aluOp;
  logic       o_subShiftDir;
  logic       i_zero;
  logic       i_negative;
  logic       o_resultWr;
  logic       o_done;
  logic       o_condTaken;

  logic [7:0] tb_a;

  always #5 i_clk = ~i_clk;

  alu_sequencer #(.WIDTH(8)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_op          (i_op),
    .i_cond        (i_cond),
    .i_reuseB      (i_reuseB),
    .i_b           (i_b),
    .o_b           (o_b),
    .o_bWr         (o_bWr),
    .o_oe          (o_oe),
    .o_aluOp       (o_aluOp),
    .o_subShiftDir (o_subShiftDir),
    .i_zero        (i_zero),
    .i_negative    (i_negative),
    .o_resultWr    (o_resultWr),
    .o_done        (o_done),
    .o_condTaken   (o_condTaken)
  );

  // Behavioural ALU: registered B and flags, combinational result bus.
  logic [7:0] alu_b, alu_res, alu_bus;
  always_comb begin
    case (o_aluOp)
      2'b00:   alu_res = o_subShiftDir ? tb_a - alu_b : tb_a + alu_b;
      2'b01:   alu_res = tb_a & alu_b;
      2'b10:   alu_res = tb_a ^ alu_b;
      default: alu_res = o_subShiftDir ? tb_a << alu_b[2:0] : tb_a >> alu_b[2:0];
    endcase
    alu_bus = o_oe ? alu_res : 8'h00;
  end

  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      alu_b      <= 8'h00;
      i_zero     <= 1'b0;
      i_negative <= 1'b0;
    end else begin
      if (o_bWr) alu_b <= o_b;
      if (o_oe) begin
        i_zero     <= (alu_res == 8'h00);
        i_negative <= alu_res[7];
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic       reuse;
    logic [7:0] b;
    logic [7:0] res;
    logic       wr;
    logic       taken;
    logic [1:0] aop;
    logic       dir;
    int         acc;
  } exp_t;

  exp_t       sb[$];
  int         acc_log[$];
  int         n_acc = 0;
  int         cnt = 0;
  logic [7:0] sb_b = 8'h00;

  always @(posedge i_clk) cnt <= cnt + 1;

  function automatic exp_t predict(logic [2:0] op, logic [1:0] cond, logic reuse,
                                   logic [7:0] a, logic [7:0] b, int acc);
    exp_t e;
    e.reuse = reuse;
    e.b     = b;
    e.acc   = acc;
    e.wr    = 1'b1;
    e.dir   = 1'b0;
    case (op)
      3'd0: begin e.res = a + b;  e.aop = 2'b00; end
      3'd1: begin e.res = a - b;  e.aop = 2'b00; e.dir = 1'b1; end
      3'd2: begin e.res = a & b;  e.aop = 2'b01; end
      3'd3: begin e.res = a ^ b;  e.aop = 2'b10; end
      3'd4: begin e.res = a << b[2:0]; e.aop = 2'b11; e.dir = 1'b1; end
      3'd5: begin e.res = a >> b[2:0]; e.aop = 2'b11; end
      3'd6: begin e.res = a - b;  e.aop = 2'b00; e.dir = 1'b1; e.wr = 1'b0; end
      default: begin e.res = a & b; e.aop = 2'b01; e.wr = 1'b0; end
    endcase
    case (cond)
      2'd1:    e.taken = (e.res == 8'h00);
      2'd2:    e.taken = e.res[7];
      2'd3:    e.taken = (e.res != 8'h00);
      default: e.taken = 1'b0;
    endcase
    return e;
  endfunction

  exp_t mon_e;
  int   mon_off;
  logic exp_bwr, exp_oe, exp_done;

  always @(negedge i_clk) begin
    if (!i_reset) begin
      check("strobe_excl", 32'($onehot0({o_bWr, o_oe, o_done})), 1);
      check("ready", o_ready, sb.size() == 0);
      if (sb.size() != 0) begin
        mon_e    = sb[0];
        mon_off  = cnt - mon_e.acc;
        exp_bwr  = !mon_e.reuse && mon_off == 0;
        exp_oe   = mon_off == (mon_e.reuse ? 0 : 1);
        exp_done = mon_off == (mon_e.reuse ? 1 : 2);
        check("bwr", o_bWr, exp_bwr);
        check("oe", o_oe, exp_oe);
        check("done", o_done, exp_done);
        check("result_wr", o_resultWr, exp_oe && mon_e.wr);
        if (exp_bwr) check("b_out", o_b, mon_e.b);
        if (exp_oe) begin
          check("bus", alu_bus, mon_e.res);
          check("alu_op", o_aluOp, mon_e.aop);
          check("sub_shift_dir", o_subShiftDir, mon_e.dir);
        end
        if (exp_done) check("cond_taken", o_condTaken, mon_e.taken);
        if (exp_done || mon_off > 2) void'(sb.pop_front());
      end else begin
        check("idle_strobes", {o_bWr, o_oe, o_done, o_resultWr}, 4'b0000);
      end
      if (i_valid && o_ready) begin
        if (!i_reuseB) sb_b = i_b;
        sb.push_back(predict(i_op, i_cond, i_reuseB, tb_a, sb_b, cnt + 1));
        acc_log.push_back(cnt + 1);
        n_acc++;
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [1:0] cond, input logic reuse,
                       input logic [7:0] b, input logic [7:0] a, input bit hold);
    int prev = n_acc;
    i_op     = op;
    i_cond   = cond;
    i_reuseB = reuse;
    i_b      = b;
    tb_a     = a;
    i_valid  = 1'b1;
    for (int k = 0; k < 12 && n_acc == prev; k++) begin
      @(posedge i_clk);
      #2;
    end
    if (n_acc == prev) check("accept_timeout", 0, 1);
    if (!hold) i_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 30 && !(sb.size() == 0 && o_ready); k++) begin
      @(posedge i_clk);
      #2;
    end
    if (!(sb.size() == 0 && o_ready)) check("idle_timeout", 0, 1);
  endtask

  int first_idx;

  initial begin
    i_reset  = 1'b1;
    i_valid  = 1'b0;
    i_op     = 3'd0;
    i_cond   = 2'd0;
    i_reuseB = 1'b0;
    i_b      = 8'h00;
    tb_a     = 8'h00;
    repeat (2) @(posedge i_clk);
    #2;
    check("rst_ready", o_ready, 1);
    check("rst_strobes", {o_bWr, o_oe, o_done, o_resultWr, o_condTaken}, 5'b00000);
    check("rst_b", o_b, 8'h00);
    check("rst_aluop", {o_aluOp, o_subShiftDir}, 3'b000);
    i_reset = 1'b0;
    @(posedge i_clk);
    #2;

    issue(3'd0, 2'd0, 1'b0, 8'h03, 8'h05, 1'b0);   // ADD 5+3, NEVER
    wait_idle();
    issue(3'd6, 2'd1, 1'b0, 8'h05, 8'h05, 1'b0);   // CMP equal, Z
    wait_idle();
    issue(3'd1, 2'd2, 1'b1, 8'hAA, 8'h03, 1'b0);   // SUB reuse B=5, N
    wait_idle();
    issue(3'd4, 2'd3, 1'b0, 8'h02, 8'h81, 1'b0);   // SHL, NZ
    wait_idle();
    issue(3'd2, 2'd1, 1'b0, 8'h0F, 8'h3C, 1'b0);   // AND, Z not taken
    wait_idle();
    issue(3'd7, 2'd1, 1'b0, 8'hF0, 8'h0F, 1'b0);   // TST zero, Z taken
    wait_idle();

    // Async reset in the middle of EXEC.
    issue(3'd0, 2'd0, 1'b0, 8'h10, 8'h01, 1'b0);
    for (int k = 0; k < 10 && !o_oe; k++) begin
      @(posedge i_clk);
      #2;
    end
    check("rst_reach_exec", o_oe, 1);
    i_reset = 1'b1;
    #1;
    check("async_oe", o_oe, 0);
    check("async_result_wr", o_resultWr, 0);
    check("async_ready", o_ready, 1);
    sb.delete();
    sb_b = 8'h00;
    @(posedge i_clk);
    #2;
    i_reset = 1'b0;
    @(posedge i_clk);
    #2;
    check("post_rst_ready", o_ready, 1);
    issue(3'd0, 2'd3, 1'b1, 8'h55, 8'h07, 1'b0);   // reuse after reset: B is 0
    wait_idle();
    issue(3'd3, 2'd3, 1'b0, 8'h0F, 8'hF0, 1'b0);   // XOR completes normally
    wait_idle();
    issue(3'd5, 2'd2, 1'b0, 8'h01, 8'h80, 1'b0);   // SHR, N not taken
    wait_idle();

    // Back-to-back: valid held high, second op accepted only in IDLE.
    first_idx = acc_log.size();
    issue(3'd3, 2'd1, 1'b0, 8'h80, 8'h80, 1'b1);
    issue(3'd5, 2'd3, 1'b0, 8'h01, 8'h80, 1'b0);
    wait_idle();
    if (acc_log.size() >= first_idx + 2)
      check("issue_interval", acc_log[first_idx + 1] - acc_log[first_idx], 4);
    else
      check("issue_count", acc_log.size() - first_idx, 2);

    repeat (2) @(posedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Downstream control stage for the 8-bit ALU. It accepts one ALU instruction per handshake and drives the ALU strobes in order: B-register load, then execute/output-enable. It then samples the registered zero/negative flags the ALU produces, evaluates a branch condition from them, and reports completion. It sits between the instruction decoder (upstream) and the ALU plus destination-register write enables (downstream).

Parameters:
WIDTH, 8, data width of the B operand path; must match the ALU.

Ports:
i_clk  in  1  system clock, all state on rising edge
i_reset  in  1  asynchronous, active-high reset
i_valid  in  1  instruction request valid
o_ready  out  1  sequencer idle, can accept an instruction
i_op  in  3  operation code (alu_seq_pkg::op_t)
i_cond  in  2  branch condition (alu_seq_pkg::cond_t)
i_reuseB  in  1  skip the B load and keep the ALU's current B register
i_b  in  WIDTH  B operand to load into the ALU
o_b  out  WIDTH  drives ALU i_b
o_bWr  out  1  drives ALU i_bWr
o_oe  out  1  drives ALU i_oe (result onto bus, flag capture)
o_aluOp  out  2  drives ALU i_aluOp
o_subShiftDir  out  1  drives ALU i_subShiftDir
i_zero  in  1  ALU registered zero flag
i_negative  in  1  ALU registered negative flag
o_resultWr  out  1  destination-register write strobe
o_done  out  1  one-cycle completion pulse
o_condTaken  out  1  condition result, valid only while o_done=1

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_reset is asynchronous and active-high.
- Reset state: IDLE. o_ready=1. All other outputs 0, including o_b, o_aluOp and o_subShiftDir. Latched op, cond and B are cleared.
- Reset asserted in any state forces IDLE immediately; no strobe may remain high.
- States: IDLE, LOAD_B, EXEC, FLAGS. The state is registered; all outputs decode from the state and the latched fields.
- IDLE:
  - o_ready=1.
  - On i_valid&o_ready at a rising edge: latch i_op, i_cond and i_b.
  - Next state is LOAD_B, or EXEC if i_reuseB=1.
  - i_valid while not IDLE is ignored; no queueing.
- LOAD_B (1 cycle): o_bWr=1, o_b=latched B. The ALU B register updates at the end of this cycle.
- EXEC (1 cycle):
  - o_oe=1; o_aluOp and o_subShiftDir are decoded from the latched op.
  - o_resultWr=1 unless op is CMP or TST.
  - The ALU captures its flags at the end of this cycle.
- FLAGS (1 cycle):
  - o_done=1.
  - o_condTaken is evaluated from i_zero/i_negative sampled in this cycle.
  - o_ready=0. Next state is IDLE.
- Latency: accept at edge T gives o_done high in cycle T+3, or T+2 with reuseB. Minimum issue interval is 4 cycles, or 3 with reuseB.
- Op decode (op: aluOp/subShiftDir):
  - ADD=0: 00/0
  - SUB=1: 00/1
  - AND=2: 01/0
  - XOR=3: 10/0
  - SHL=4: 11/1
  - SHR=5: 11/0
  - CMP=6: 00/1, no write
  - TST=7: 01/0, no write
- Cond decode:
  - NEVER=0: 0
  - Z=1: i_zero
  - N=2: i_negative
  - NZ=3: ~i_zero
- Outside EXEC, o_aluOp/o_subShiftDir hold the latched decode; they are don't-care to the ALU.
- o_b holds the latched B in all states; it is 0 after reset.
- reuseB after reset uses the ALU B register value 0. This is legal and not an error.
- Strobes are mutually exclusive per cycle: o_bWr, o_oe and o_done are never high together.

Decomposition:
- alu_seq_pkg holds:
  - op_t enum (3 bits, values above)
  - cond_t enum (2 bits)
  - state_t enum
  - constants ALU_OP_ADDSUB=2'b00, ALU_OP_AND=2'b01, ALU_OP_XOR=2'b10, ALU_OP_SHIFT=2'b11
- One combinational sub-module, alu_op_decode: op_t in, {aluOp, subShiftDir, writesResult} out. It is reused by the instruction decoder.

Test Plan:
(Bench instantiates the sequencer plus the ALU, with A driven by the bench.)
1. ADD, i_b=0x03, A=0x05, cond=NEVER, accept at T -> o_bWr in T+1; o_oe and o_resultWr in T+2 with bus=0x08; o_done in T+3 with o_condTaken=0; flags Z=0, N=0.
2. CMP, i_b=0x05, A=0x05, cond=Z -> o_resultWr never asserted; o_done with o_condTaken=1.
3. SUB with reuseB=1 right after test 2, A=0x03 -> o_bWr never asserted; o_oe at T+1, bus=0xFE; o_done at T+2; cond=N gives o_condTaken=1.
4. SHL, i_b=0x02, A=0x81 -> o_aluOp=11, o_subShiftDir=1; bus=0x04; with cond=NZ, o_condTaken=1.
5. Assert i_reset mid-EXEC -> o_oe and o_resultWr drop without waiting for a clock edge; o_ready=1 after release; next request completes normally.
6. i_valid held high with two queued ops -> second accepted only in IDLE, exactly 4 cycles after the first; no strobe overlap; o_ready low in LOAD_B/EXEC/FLAGS.
